count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Run-controller for the divided-clock nibble counter datapath.
//  - Generates a programmable prescaled tick instead of a derived clock, so the whole block runs on clk.
//  - Sequences a counter from 0 up to a programmed limit and signals completion.
//  - Supports start/stop control. Sits between host/control logic and the count display/consumer.
// PARAMETERS
//  DIV_W  3  prescaler width; tick period = div_sel+1 clk cycles (max 2**DIV_W)
//  CNT_W  4  counter width; count output and limit width
// PORTS
//  clk      in   1      system clock; all state on posedge clk
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      begin a run (sampled in IDLE only)
//  stop     in   1      abort a run (sampled in RUN only)
//  div_sel  in   DIV_W  prescale select, captured at start
//  limit    in   CNT_W  terminal count value, captured at start
//  reload   in   1      auto-reload request (present only with AUTO_RELOAD_EN)
//  count    out  CNT_W  current count, registered
//  tick     out  1      1-cycle pulse, high in the cycle count updates
//  busy     out  1      high while in RUN
//  done     out  1      1-cycle pulse on run completion
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. All outputs are registered.
//  - Reset (async, any state): state=IDLE, count=0, prescaler=0, shadow regs=0, tick=0, busy=0, done=0.
//  - IDLE, start=1:
//    - Next cycle: state=RUN, busy=1, count=0, prescaler=0.
//    - div_q<=div_sel and lim_q<=limit are captured.
//    - Otherwise count holds its value.
//  - RUN, prescaler:
//    - Increments every clk.
//    - When prescaler==div_q it wraps to 0 and a tick occurs on the next edge.
//    - First tick is div_q+1 cycles after RUN entry.
//  - RUN, tick with count!=lim_q: count<=count+1, tick=1 for one cycle.
//  - RUN, tick with count==lim_q (terminal):
//    - count<=0, tick=1, state=DONE, done=1 and busy=0 in that cycle.
//  - Run length: start accepted to done = (lim_q+1)*(div_q+1) cycles.
//  - DONE: lasts exactly one cycle, then IDLE. start is ignored in DONE.
//  - Boundary cases:
//    - div_sel=0: tick every cycle.
//    - limit=0: terminal on first tick.
//    - limit=2**CNT_W-1: full wrap, no overflow beyond terminal.
//  - RUN, stop=1 (priority over a same-cycle tick or terminal):
//    - Next cycle: IDLE, busy=0, done=0, tick=0, count holds its last value.
//  - start during RUN and stop during IDLE are ignored.
//  - div_sel/limit changes during RUN have no effect; they are shadowed.
//  - Count arithmetic is CNT_W-bit unsigned; the prescaler is DIV_W-bit unsigned.
// CONFIGURATION
//  AUTO_RELOAD_EN defined:
//    - The reload port exists.
//    - On a terminal tick with reload=1: count<=0, done pulses, state stays RUN, busy stays 1, prescaler continues.
//    - reload=0: terminal behaves as in base mode.
//  AUTO_RELOAD_EN undefined:
//    - No reload port. Every run is one-shot (RUN->DONE->IDLE).
// TESTING
//  1. rst, start with div_sel=3, limit=4:
//     - tick every 4 cycles; count 1,2,3,4,0.
//     - done 1-cycle pulse 20 cycles after start; busy falls with done.
//  2. div_sel=0, limit=0, start:
//     - tick and done in the first RUN cycle after entry; count stays 0; back to IDLE 1 cycle later.
//  3. div_sel=1, limit=9, stop asserted in the same cycle count becomes 3:
//     - IDLE next cycle, count holds 3, no done, busy=0.
//  4. start with limit=5, then change limit to 1 and div_sel to 0 mid-run:
//     - the run still ends at count 5 with the original period.
//  5. async rst pulse mid-run at count=6 (between clock edges):
//     - count=0, busy=0, tick=0 immediately, no done.
//  6. AUTO_RELOAD_EN, div_sel=1, limit=2, reload=1:
//     - count 1,2,0 repeating; done pulses every 6 cycles; busy stays 1.
//     - drop reload: the next terminal goes to DONE then IDLE.

Source files
------------

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//
// Run controller for the nibble counter datapath. The whole block runs on clk.
// It does not derive a divided clock. Instead, a prescaler produces a tick
// every (div_sel+1) clk cycles. The counter steps from 0 up to a programmed
// limit, one step per tick, and then signals completion.
//
// Optional feature macro: AUTO_RELOAD_EN
//   When it is defined, the reload port exists. A terminal tick taken while
//   reload=1 restarts the count and stays in RUN. When it is undefined, every
//   run is one-shot.
//
// Parameters
//   DIV_W   prescaler width; tick period = div_sel+1 clk cycles
//   CNT_W   counter width (count and limit)
//
// Ports
//   clk      in   system clock; all state changes on posedge clk
//   rst      in   asynchronous active-high reset
//   start    in   begin a run (only sampled in IDLE)
//   stop     in   abort a run (only sampled in RUN)
//   div_sel  in   prescale select; captured when start is accepted
//   limit    in   terminal count; captured when start is accepted
//   reload   in   auto-reload request (only with AUTO_RELOAD_EN)
//   count    out  current count (registered)
//   tick     out  1-cycle pulse; high in the cycle count updates
//   busy     out  high while in RUN
//   done     out  1-cycle pulse on run completion
//
// State table
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; count holds its last value
//   RUN     | prescaler running, count advances on each tick
//   DONE    | single cycle after a terminal tick; start is ignored
// -----------------------------------------------------------------------------
module count_sequencer #(
    parameter int DIV_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [CNT_W-1:0] limit,
`ifdef AUTO_RELOAD_EN
    input  logic             reload,
`endif
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state, state_nx;
    logic [DIV_W-1:0] presc, presc_nx;
    logic [DIV_W-1:0] div_q, div_nx;
    logic [CNT_W-1:0] lim_q, lim_nx;
    logic [CNT_W-1:0] count_nx;
    logic             tick_nx;
    logic             busy_nx;
    logic             done_nx;

    logic             period_end;
    logic             at_limit;
    logic             reload_req;

`ifdef AUTO_RELOAD_EN
    assign reload_req = reload;
`else
    assign reload_req = 1'b0;
`endif

    // The prescaler wraps on the edge where it equals div_q. That same edge
    // produces the tick, so the first tick comes div_q+1 cycles after RUN
    // is entered.
    assign period_end = (presc == div_q);
    assign at_limit   = (count == lim_q);

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        div_nx   = div_q;
        lim_nx   = lim_q;
        count_nx = count;
        tick_nx  = 1'b0;
        busy_nx  = busy;
        done_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = ST_RUN;
                    busy_nx  = 1'b1;
                    count_nx = '0;
                    presc_nx = '0;
                    div_nx   = div_sel;
                    lim_nx   = limit;
                end
            end

            ST_RUN: begin
                // stop takes priority over a tick or terminal in the same
                // cycle. The abandoned count stays visible.
                if (stop) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                end else if (period_end) begin
                    presc_nx = '0;
                    tick_nx  = 1'b1;
                    if (!at_limit) begin
                        count_nx = count + 1'b1;
                    end else begin
                        count_nx = '0;
                        done_nx  = 1'b1;
                        if (reload_req) begin
                            // Keep running with the same shadowed settings.
                            // The prescaler has already wrapped, so the
                            // tick cadence is unbroken.
                            busy_nx = 1'b1;
                        end else begin
                            state_nx = ST_DONE;
                            busy_nx  = 1'b0;
                        end
                    end
                end else begin
                    presc_nx = presc + 1'b1;
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
            end

            default: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            presc <= '0;
            div_q <= '0;
            lim_q <= '0;
            count <= '0;
            tick  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            div_q <= div_nx;
            lim_q <= lim_nx;
            count <= count_nx;
            tick  <= tick_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for count_sequencer.
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the
// same point, so a sample shows the state left by the edge just taken.
// Expected values are written out by hand from the intended behaviour.
// In the per-cycle loops they come from short closed-form expressions of
// the cycle index k, where k counts edges after start was accepted.
// -----------------------------------------------------------------------------
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] div_sel = 3'd0;
    logic [3:0] limit = 4'd0;
    logic       reload = 1'b0;
    logic [3:0] count;
    logic       tick;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_cnt;
    logic       exp_tick;
    logic       exp_busy;
    logic       exp_done;

    count_sequencer #(.DIV_W(3), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .div_sel (div_sel),
        .limit   (limit),
`ifdef AUTO_RELOAD_EN
        .reload  (reload),
`endif
        .count   (count),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({count, tick, busy, done} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset: got cnt/tick/busy/done=%h expected %h",
                     {count, tick, busy, done}, 7'h00);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({count, tick, busy, done} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", {count, tick, busy, done}, 7'h00);
        end
    endtask

    // div_sel=3, limit=4: a tick every 4 cycles, count 1,2,3,4,0, and done
    // 20 cycles after start. start is held during DONE and must be ignored.
    task automatic test_basic();
        div_sel = 3'd3;
        limit   = 4'd4;
        start   = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, tick, busy, done} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_entry: got %h expected %h",
                     {count, tick, busy, done}, {4'd0, 1'b0, 1'b1, 1'b0});
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_cnt  = 4'((k / 4) % 5);
            exp_tick = (k % 4 == 0);
            exp_busy = (k < 20);
            exp_done = (k == 20);
            checks++;
            if ({count, tick, busy, done} !== {exp_cnt, exp_tick, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL basic k=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, {exp_cnt, exp_tick, exp_busy, exp_done});
            end
            if (k == 20) start = 1'b1;
        end
        step();
        start = 1'b0;
        checks++;
        if ({count, tick, busy, done} !== 7'h00) begin
            errors++;
            $display("FAIL basic_done_start_ignored: got %h expected %h",
                     {count, tick, busy, done}, 7'h00);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b expected 0", busy);
        end
    endtask

    // div_sel=0, limit=0: terminal on the very first RUN edge.
    task automatic test_min();
        div_sel = 3'd0;
        limit   = 4'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({count, tick, busy, done} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL min_entry: got %h expected %h",
                     {count, tick, busy, done}, {4'd0, 1'b0, 1'b1, 1'b0});
        end
        step();
        checks++;
        if ({count, tick, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL min_terminal: got %h expected %h",
                     {count, tick, busy, done}, {4'd0, 1'b1, 1'b0, 1'b1});
        end
        step();
        checks++;
        if ({count, tick, busy, done} !== 7'h00) begin
            errors++;
            $display("FAIL min_idle: got %h expected %h", {count, tick, busy, done}, 7'h00);
        end
    endtask

    // div_sel=1, limit=9: stop is raised while count shows 3 and the run is
    // abandoned with the count frozen at 3.
    task automatic test_stop();
        div_sel = 3'd1;
        limit   = 4'd9;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if ({count, tick, busy, done} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stop_pre: got %h expected %h",
                     {count, tick, busy, done}, {4'd3, 1'b1, 1'b1, 1'b0});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({count, tick, busy, done} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stop_hold c=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, {4'd3, 1'b0, 1'b0, 1'b0});
            end
            step();
        end
    endtask

    // stop lands on the same edge that would have ticked. stop must win.
    task automatic test_stop_priority();
        div_sel = 3'd1;
        limit   = 4'd9;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if ({count, tick, busy, done} !== {4'd2, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stop_prio_pre: got %h expected %h",
                     {count, tick, busy, done}, {4'd2, 1'b0, 1'b1, 1'b0});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({count, tick, busy, done} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_prio: got %h expected %h",
                     {count, tick, busy, done}, {4'd2, 1'b0, 1'b0, 1'b0});
        end
    endtask

    // div_sel=2, limit=5 are captured, then both inputs change. start is
    // also held through the first part of the run. None of this may
    // disturb the run.
    task automatic test_shadow();
        div_sel = 3'd2;
        limit   = 4'd5;
        start   = 1'b1;
        step();
        div_sel = 3'd0;
        limit   = 4'd1;
        for (int k = 1; k <= 18; k++) begin
            start = (k < 10);
            step();
            exp_cnt  = 4'((k / 3) % 6);
            exp_tick = (k % 3 == 0);
            exp_busy = (k < 18);
            exp_done = (k == 18);
            checks++;
            if ({count, tick, busy, done} !== {exp_cnt, exp_tick, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL shadow k=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, {exp_cnt, exp_tick, exp_busy, exp_done});
            end
        end
        step();
        checks++;
        if ({count, tick, busy, done} !== 7'h00) begin
            errors++;
            $display("FAIL shadow_idle: got %h expected %h", {count, tick, busy, done}, 7'h00);
        end
    endtask

    // limit=15 with div_sel=0: the count covers the full range and wraps to
    // 0 only at the terminal tick.
    task automatic test_limit_max();
        div_sel = 3'd0;
        limit   = 4'd15;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_cnt  = 4'(k % 16);
            exp_tick = 1'b1;
            exp_busy = (k < 16);
            exp_done = (k == 16);
            checks++;
            if ({count, tick, busy, done} !== {exp_cnt, exp_tick, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL limit_max k=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, {exp_cnt, exp_tick, exp_busy, exp_done});
            end
        end
        step();
        checks++;
        if ({count, tick, busy, done} !== 7'h00) begin
            errors++;
            $display("FAIL limit_max_idle: got %h expected %h", {count, tick, busy, done}, 7'h00);
        end
    endtask

    // rst is pulsed between edges while count=6. The outputs must clear
    // without waiting for a clock edge.
    task automatic test_async_reset();
        div_sel = 3'd0;
        limit   = 4'd9;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if ({count, tick, busy, done} !== {4'd6, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_pre: got %h expected %h",
                     {count, tick, busy, done}, {4'd6, 1'b1, 1'b1, 1'b0});
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({count, tick, busy, done} !== 7'h00) begin
            errors++;
            $display("FAIL async_rst: got %h expected %h", {count, tick, busy, done}, 7'h00);
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({count, tick, busy, done} !== 7'h00) begin
                errors++;
                $display("FAIL async_after c=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, 7'h00);
            end
        end
    endtask

`ifdef AUTO_RELOAD_EN
    // div_sel=1, limit=2 with reload=1: count 1,2,0 repeats and done pulses
    // every 6 cycles. reload is dropped after k=18, so the terminal at
    // k=24 ends the run.
    task automatic test_reload();
        reload  = 1'b1;
        div_sel = 3'd1;
        limit   = 4'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            exp_cnt  = 4'((k / 2) % 3);
            exp_tick = (k % 2 == 0);
            exp_busy = (k < 24);
            exp_done = (k % 6 == 0) && (k <= 24);
            checks++;
            if ({count, tick, busy, done} !== {exp_cnt, exp_tick, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reload k=%0d: got %h expected %h", k,
                         {count, tick, busy, done}, {exp_cnt, exp_tick, exp_busy, exp_done});
            end
            if (k == 18) reload = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_min();
        test_stop();
        test_stop_priority();
        test_shadow();
        test_limit_max();
        test_async_reset();
`ifdef AUTO_RELOAD_EN
        test_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
